// File: rtl/ann_pkg.sv
// Shared definitions for the ANN post-processing stages.
package ann_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } relu_argmax_state_e;

    // Sign-only rectifier on a default-width word.
    // It works for any two's-complement or sign-magnitude encoding.
    function automatic logic [DEFAULT_WIDTH-1:0] relu(input logic [DEFAULT_WIDTH-1:0] value);
        return value[DEFAULT_WIDTH-1] ? '0 : value;
    endfunction

endpackage

// File: rtl/relu_argmax.sv
// Sequential ReLU + argmax stage.
// It latches one vector and scans it one element per cycle.
// It publishes the rectified vector, the max value and the argmax index
// under an enable/done level handshake.
module relu_argmax
    import ann_pkg::*;
#(
    parameter  int SIZE  = 4,
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] data_in [SIZE],
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out [SIZE],
    output logic [WIDTH-1:0] max_value,
    output logic [IDX_W-1:0] max_index
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

    relu_argmax_state_e state;

    logic [WIDTH-1:0] buffer  [SIZE];
    logic [WIDTH-1:0] staging [SIZE];
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] best_value;
    logic [IDX_W-1:0] best_index;

    logic [WIDTH-1:0] current;
    logic [WIDTH-1:0] rect;
    logic             take;
    logic [WIDTH-1:0] next_value;
    logic [IDX_W-1:0] next_index;

    // Select the element under scan, rectify it and decide whether it is the new maximum.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        current = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (idx == IDX_W'(i)) current = buffer[i];
        end
        rect       = current[WIDTH-1] ? '0 : current;
        // The strict compare makes the lowest index win a tie.
        take       = $signed(rect) > $signed(best_value);
        next_value = take ? rect : best_value;
        next_index = take ? idx : best_index;
    end

    // Capture the input vector on the start edge, and stage rectified elements while scanning.
    always_ff @(posedge clk) begin
        // NOTE: buffer and staging are plain storage that is always written before it is read.
        // They carry no reset, which keeps the reset mux off the data RAM.
        if (state == IDLE && enable) begin
            for (int i = 0; i < SIZE; i++) buffer[i] <= data_in[i];
        end
        if (state == SCAN) begin
            for (int i = 0; i < SIZE; i++) begin
                if (idx == IDX_W'(i)) staging[i] <= rect;
            end
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            idx        <= '0;
            best_value <= '0;
            best_index <= '0;
            max_value  <= '0;
            max_index  <= '0;
            for (int i = 0; i < SIZE; i++) data_out[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state      <= SCAN;
                        busy       <= 1'b1;
                        idx        <= '0;
                        best_value <= '0;
                        best_index <= '0;
                    end
                end
                SCAN: begin
                    best_value <= next_value;
                    best_index <= next_index;
                    if (idx == LAST_IDX) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        max_value <= next_value;
                        max_index <= next_index;
                        // The last element is still in flight to staging, so forward it directly.
                        for (int i = 0; i < SIZE; i++) begin
                            data_out[i] <= (idx == IDX_W'(i)) ? rect : staging[i];
                        end
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (!enable) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_relu_argmax.sv
// Directed self-checking bench for relu_argmax (SIZE = 4 and SIZE = 1 instances).
module tb_relu_argmax;

    logic        clk = 1'b0;
    logic        rst;
    logic        en4, en1;
    logic [31:0] d4 [4];
    logic [31:0] o4 [4];
    logic [31:0] d1 [1];
    logic [31:0] o1 [1];
    logic        busy4, done4, busy1, done1;
    logic [31:0] mv4, mv1;
    logic [1:0]  mi4;
    logic        mi1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    relu_argmax #(.SIZE(4), .WIDTH(32)) dut4 (
        .clk(clk), .rst(rst), .enable(en4), .data_in(d4),
        .busy(busy4), .done(done4), .data_out(o4),
        .max_value(mv4), .max_index(mi4)
    );

    relu_argmax #(.SIZE(1), .WIDTH(32)) dut1 (
        .clk(clk), .rst(rst), .enable(en1), .data_in(d1),
        .busy(busy1), .done(done1), .data_out(o1),
        .max_value(mv1), .max_index(mi1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out4(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic [31:0] d,
                              input logic [31:0] mv, input logic [31:0] mi);
        logic [31:0] exp [4];
        exp = '{a, b, c, d};
        for (int i = 0; i < 4; i++) check($sformatf("%s data_out[%0d]", tag, i), o4[i], exp[i]);
        check({tag, " max_value"}, mv4, mv);
        check({tag, " max_index"}, {30'd0, mi4}, mi);
    endtask

    // Start edge plus SIZE scan edges, checking busy/done timing along the way.
    // It optionally scribbles over data_in after the capture edge.
    task automatic run4(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d, input bit scribble);
        d4  = '{a, b, c, d};
        en4 = 1'b1;
        step();
        check({tag, " busy after start"}, {31'd0, busy4}, 32'd1);
        if (scribble) d4 = '{32'd100, 32'd100, 32'd100, 32'd100};
        for (int k = 1; k <= 4; k++) begin
            if (k < 4) check($sformatf("%s done low edge %0d", tag, k - 1), {31'd0, done4}, 32'd0);
            step();
        end
        check({tag, " done"}, {31'd0, done4}, 32'd1);
        check({tag, " busy low"}, {31'd0, busy4}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        en4 = 1'b0;
        en1 = 1'b0;
        d4  = '{default: 32'd0};
        d1  = '{default: 32'd0};
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst busy", {31'd0, busy4}, 32'd0);
        check("rst done", {31'd0, done4}, 32'd0);
        check_out4("rst", 0, 0, 0, 0, 0, 0);

        // Mixed vector
        run4("mixed", 32'd5, -32'sd3, 32'd12, 32'd0, 1'b0);
        check_out4("mixed", 5, 0, 12, 0, 12, 2);
        en4 = 1'b0;
        step();
        check("mixed done drop", {31'd0, done4}, 32'd0);
        check_out4("mixed hold", 5, 0, 12, 0, 12, 2);

        // All non-positive
        run4("neg", -32'sd1, -32'sd7, 32'h8000_0000, -32'sd2, 1'b0);
        check_out4("neg", 0, 0, 0, 0, 0, 0);
        en4 = 1'b0;
        step();

        // Ties and a data_in change after capture
        run4("tie", 32'd9, 32'd9, 32'd3, 32'd9, 1'b1);
        check_out4("tie", 9, 9, 3, 9, 9, 0);

        // Enable held high in DONE: no restart
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("hold done %0d", k), {31'd0, done4}, 32'd1);
            check($sformatf("hold busy %0d", k), {31'd0, busy4}, 32'd0);
        end
        en4 = 1'b0;
        step();
        check("drop done", {31'd0, done4}, 32'd0);
        check_out4("drop hold", 9, 9, 3, 9, 9, 0);

        // Restart; old results must stay until the new done
        d4  = '{32'd1, 32'd2, 32'd3, 32'd4};
        en4 = 1'b1;
        step();
        check("restart busy", {31'd0, busy4}, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            if (k < 4) check_out4($sformatf("restart hold %0d", k), 9, 9, 3, 9, 9, 0);
            step();
        end
        check("restart done", {31'd0, done4}, 32'd1);
        check_out4("restart", 1, 2, 3, 4, 4, 3);
        en4 = 1'b0;
        step();

        // Reset during SCAN aborts the run
        d4  = '{32'd50, 32'd60, 32'd70, 32'd80};
        en4 = 1'b1;
        step();
        step();
        step();
        rst = 1'b1;
        en4 = 1'b0;
        step();
        check("abort busy", {31'd0, busy4}, 32'd0);
        check("abort done", {31'd0, done4}, 32'd0);
        check_out4("abort", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step();
        check("abort idle done", {31'd0, done4}, 32'd0);
        run4("post", 32'd0, 32'd0, 32'd0, 32'd7, 1'b0);
        check_out4("post", 0, 0, 0, 7, 7, 3);
        en4 = 1'b0;
        step();

        // SIZE = 1 instance
        d1  = '{-32'sd5};
        en1 = 1'b1;
        step();
        check("s1 busy", {31'd0, busy1}, 32'd1);
        check("s1 done early", {31'd0, done1}, 32'd0);
        step();
        check("s1 done", {31'd0, done1}, 32'd1);
        check("s1 data_out", o1[0], 32'd0);
        check("s1 max_value", mv1, 32'd0);
        check("s1 max_index", {31'd0, mi1}, 32'd0);
        en1 = 1'b0;
        step();
        d1  = '{32'd6};
        en1 = 1'b1;
        step();
        step();
        check("s1 pos done", {31'd0, done1}, 32'd1);
        check("s1 pos data_out", o1[0], 32'd6);
        check("s1 pos max_value", mv1, 32'd6);
        check("s1 pos max_index", {31'd0, mi1}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/relu_argmax.md
# relu_argmax

Sequential post-processing stage directly downstream of the linear layer. Latches one OUTPUT_SIZE-wide result vector and scans it one element per cycle. For each element it applies ReLU and tracks the running maximum. It publishes the rectified vector, the max value and the argmax index under the same enable/done level handshake the layer stages use, so it can drive a following layer or serve as the classifier head.

## Interface
Parameters:
- SIZE, 4, number of elements per vector; equals the upstream OUTPUT_SIZE; must be ≥ 1.
- WIDTH, 32, element width; two's-complement signed.
- IDX_W, (SIZE > 1 ? $clog2(SIZE) : 1), width of the index outputs; derived, not overridden.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  start request, level; sampled only in IDLE.
- data_in  in  WIDTH×SIZE (unpacked [SIZE])  vector from the linear layer; sampled only on the start edge.
- busy  out  1  high in SCAN.
- done  out  1  high in DONE; results valid.
- data_out  out  WIDTH×SIZE (unpacked [SIZE])  ReLU(data_in).
- max_value  out  WIDTH  largest rectified element.
- max_index  out  IDX_W  index of max_value; lowest index wins ties.

## Operation
- States:
  - IDLE: wait for enable = 1, then capture data_in into an internal buffer, set scan index to 0, set best_value to 0 and best_index to 0, and go to SCAN.
  - SCAN: each cycle process buffer[idx]:
    - r = (msb set) ? 0 : value.
    - Store r in the staging vector.
    - If r > best_value (strict, signed compare), update best_value and best_index.
    - If idx == SIZE-1, go to DONE; otherwise increment idx.
  - DONE: hold results; when enable = 0, go to IDLE.
- data_out, max_value and max_index are registered. They update only on the SCAN→DONE edge. At all other times they hold the last result, so they are stable whenever done = 1.
- ReLU is sign-only, so the encoding is format-agnostic. 0x8000_0000 maps to 0.
- Because best_value starts at 0, an all-non-positive vector yields max_value = 0 and max_index = 0.
- enable is ignored in SCAN. A change on data_in after the capture edge has no effect.
- If enable stays high in DONE, the block stays in DONE. A new run requires enable = 0 for ≥ 1 cycle, then 1.

## Timing
- Reset: state = IDLE and busy = done = 0. data_out, max_value and max_index all reset to 0.
- Reset mid-SCAN or in DONE aborts the run on the same edge; no partial result is published.
- Latency:
  - The start edge (edge 0) is the edge where IDLE samples enable = 1.
  - Element i is processed at edge 1+i.
  - done rises, and the results become visible, after edge SIZE.
  - busy is high from after edge 0 until after edge SIZE.
- After enable falls in DONE, done drops on the next edge. The earliest next start is the edge after that.
- Throughput: one vector per SIZE+2 cycles minimum.
- SIZE = 1: one SCAN cycle, with max_index fixed at 0.

## Structure
- Shared ann_pkg holds:
  - the default WIDTH constant;
  - a `relu_argmax_state_e` enum {IDLE, SCAN, DONE};
  - a `relu` function on a WIDTH-bit word, reused later by the activation-only stage.
- No sub-module. The block is a single FSM with one comparator and a buffer of SIZE words; a separate datapath module adds nothing.

## Test plan
- Mixed vector, SIZE = 4: data_in = {5, -3, 12, 0} → after 4 cycles done = 1, data_out = {5, 0, 12, 0}, max_value = 12, max_index = 2.
- All negative: {-1, -7, 0x8000_0000, -2} → data_out all 0, max_value = 0, max_index = 0.
- Tie: {9, 9, 3, 9} → max_index = 0, max_value = 9. Also change data_in mid-SCAN and check the result is unchanged.
- Handshake: hold enable high after done → done stays 1, no restart. Drop enable for 1 cycle then raise it with {1, 2, 3, 4} → second run gives max_index = 3. Check the previous outputs hold until the new done.
- Reset at SCAN cycle 2 → next edge busy = 0, done = 0, all outputs 0. A following run with {0, 0, 0, 7} gives max_index = 3.
- SIZE = 1 instance: {-5} → done after 1 cycle, data_out = {0}, max_index = 0.
